// File: rtl/iter_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_FAST_SPECIAL_EN: zero-operand, divide-by-zero and overflow requests skip the iteration.
module iter_muldiv #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            zero,
  output logic            busy
);

  localparam int unsigned AW = 2 * XLEN;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic            dz_q, dz_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] out_q, out_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            in_neg, in_dz;
  logic            last_step;

`ifdef MULDIV_FAST_SPECIAL_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic            fast_q, fast_d;
  logic            in_ovf, in_fast;
  logic [XLEN-1:0] in_fast_res;
`endif

  // Request decode: operand magnitudes, result sign and special cases.
  always_comb begin
    a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    b_signed = op[2] ? ~op[0] : ~op[1];
    a_neg    = a_signed & A[XLEN-1];
    b_neg    = b_signed & B[XLEN-1];
    a_mag    = a_neg ? (~A + XLEN'(1)) : A;
    b_mag    = b_neg ? (~B + XLEN'(1)) : B;
    // Remainder follows the dividend; every other signed result takes the product sign.
    in_neg   = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
    in_dz    = op[2] & (B == '0);
`ifdef MULDIV_FAST_SPECIAL_EN
    in_ovf      = op[2] & ~op[0] & (A == MIN_NEG) & (&B);
    in_fast     = in_dz | in_ovf | (A == '0) | (B == '0);
    in_fast_res = '0;
    if (in_dz) begin
      in_fast_res = op[1] ? A : '1;
    end else if (in_ovf) begin
      in_fast_res = op[1] ? '0 : A;
    end
`endif
  end

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh, div_diff;
  logic            div_ge;
  logic [AW-1:0]   step_acc;
  logic [AW-1:0]   prod_fix;
  logic [XLEN-1:0] div_sel, div_fix, calc_res;

  // One iteration step plus final sign fix-up and result selection.
  always_comb begin
    mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    div_sh   = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, mcand_q};
    div_ge   = ~div_diff[XLEN];
    if (op_q[2]) begin
      step_acc = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end else begin
      step_acc = {mul_sum, acc_q[XLEN-1:1]};
    end

    prod_fix = neg_q ? (~step_acc + AW'(1)) : step_acc;
    div_sel  = op_q[1] ? step_acc[AW-1:XLEN] : step_acc[XLEN-1:0];
    div_fix  = neg_q ? (~div_sel + XLEN'(1)) : div_sel;
    if (dz_q && !op_q[1]) begin
      div_fix = '1;
    end

    if (op_q[2]) begin
      calc_res = div_fix;
    end else if (op_q[1:0] == 2'b00) begin
      calc_res = prod_fix[XLEN-1:0];
    end else begin
      calc_res = prod_fix[AW-1:XLEN];
    end
  end

  assign last_step = (cnt_q == CNTW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_CALC;
      S_CALC:  if (last_step) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    op_d    = op_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
`ifdef MULDIV_FAST_SPECIAL_EN
    fast_d  = fast_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = op;
          neg_d = in_neg;
          dz_d  = in_dz;
          cnt_d = CNTW'(XLEN);
          if (op[2]) begin
            mcand_d = b_mag;
            acc_d   = {{XLEN{1'b0}}, a_mag};
          end else begin
            mcand_d = a_mag;
            acc_d   = {{XLEN{1'b0}}, b_mag};
          end
`ifdef MULDIV_FAST_SPECIAL_EN
          // Bypass spends a single cycle in CALC and delivers the precomputed result.
          fast_d = in_fast;
          if (in_fast) begin
            cnt_d = CNTW'(1);
            acc_d = {{XLEN{1'b0}}, in_fast_res};
          end
`endif
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNTW'(1);
        if (last_step) begin
          out_d = calc_res;
`ifdef MULDIV_FAST_SPECIAL_EN
          if (fast_q) begin
            out_d = acc_q[XLEN-1:0];
          end
`endif
        end
      end
      default: ;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      neg_q       <= 1'b0;
      dz_q        <= 1'b0;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MULDIV_FAST_SPECIAL_EN
      fast_q      <= 1'b0;
`endif
    end else begin
      op_q        <= op_d;
      neg_q       <= neg_d;
      dz_q        <= dz_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef MULDIV_FAST_SPECIAL_EN
      fast_q      <= fast_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out       = out_q;
  assign zero      = (out_q == '0);

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed and random bench for iter_muldiv (XLEN=32) with a result scoreboard queue.
module tb_iter_muldiv;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        zero;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  iter_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model using wide host arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
      OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return 32'(sa / sb);
      end
      OP_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_SPECIAL_EN
    if (a == 32'd0 || b == 32'd0) return 1;
    if (o[2] && !o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
    return 32;
  endfunction

  // Issue one request from a negedge, check latency/result, hold DONE for 'hold' cycles, then retire.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int hold, input string tag);
    int lat;
    int guard;
    logic [31:0] e;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; A = a; B = b;
    exp_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
    check({tag, "/busy"}, {62'd0, busy, in_ready}, 64'd2);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat(o, a, b)));
    e = exp_q.pop_front();
    check({tag, "/out"}, 64'(out), 64'(e));
    check({tag, "/zero"}, 64'(zero), 64'(e == 32'd0));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; A = $urandom; B = $urandom;
      @(negedge clk);
      check({tag, "/hold"}, {out_valid, in_ready, out}, {2'b10, e});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/retire"}, {61'd0, out_valid, in_ready, busy}, 64'd2);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset/out", 64'(out), 64'd0);
    check("reset/zero", 64'(zero), 64'd1);
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/in_ready", 64'(in_ready), 64'd1);
    check("reset/busy", 64'(busy), 64'd0);

    run_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul_7_m3");
    run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu_ff");
    run_op(OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 0, "mulh_ff");
    run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_ff");
    run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0, "div_m7_2");
    run_op(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0, "rem_m7_2");
    run_op(OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 0, "divu_by0");
    run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 0, "rem_ovf");
    run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0, "div_ovf");
    run_op(OP_DIV,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 0, "div_neg_by0");
    run_op(OP_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 0, "rem_neg_by0");
    run_op(OP_REMU,   32'd100,        32'd7,         32'd2,         0, "remu_100_7");
    run_op(OP_MUL,    32'd0,          32'd12345,     32'd0,         0, "mul_zero");
    run_op(OP_DIVU,   32'd1000,       32'd3,         32'd333,       5, "hold_divu");

    // Abort a divide with reset in its 10th CALC cycle.
    in_valid = 1'b1; op = OP_DIV; A = 32'd1000; B = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("abort/pre_valid", 64'(out_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort/state", {59'd0, out_valid, in_ready, busy, zero, |out}, 64'b01010);
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 0, "divu_after_rst");

    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 1) rb = 32'($urandom_range(1, 20));
      if (i % 7 == 3) ra = -ra;
      run_op(ro, ra, rb, ref_res(ro, ra, rb), i % 3, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
